// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug-select initiator.
package dbg_pkg;

  // Debugger command opcodes as they arrive on cmd_op.
  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_UNLOCK = 2'd1,
    OP_READ   = 2'd2,
    OP_LOCK   = 2'd3
  } dbg_op_e;

  // Controller FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESP    = 3'd4,
    ST_LOCKOUT = 3'd5
  } dbg_state_e;

  // Selector that may only be driven to the target while unlocked.
  localparam logic [3:0] SENS_SEL = 4'hF;
  // Selector value meaning "no access" on dbg_mode.
  localparam logic [3:0] DBG_IDLE = 4'h0;

endpackage

// File: rtl/dbg_lockout_timer.sv
// Failed-unlock counter and lockout down-counter.
// at_max flags that the fail budget is exhausted; done pulses on the
// last lockout cycle, at which point the fail counter is also cleared.
module dbg_lockout_timer #(
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic fail,
  input  logic success,
  input  logic start,
  output logic at_max,
  output logic done
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          active_q, active_d;
  logic          expire;

  // The lockout ends on the cycle the down-counter has reached zero.
  assign expire = active_q && (lock_cnt_q == '0);

  // Next-state for the fail counter (saturating) and the lockout counter.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = lock_cnt_q;
    active_d   = active_q;
    if (success) begin
      fail_cnt_d = '0;
    end else if (fail && (fail_cnt_q != FAIL_MAX)) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
    end
    if (start) begin
      active_d   = 1'b1;
      lock_cnt_d = LOCK_LAST;
    end else if (expire) begin
      active_d   = 1'b0;
      fail_cnt_d = '0;
    end else if (active_q) begin
      lock_cnt_d = lock_cnt_q - 1'b1;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt_q <= '0;
      lock_cnt_q <= '0;
      active_q   <= 1'b0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      active_q   <= active_d;
    end
  end

  assign at_max = (fail_cnt_q == FAIL_MAX);
  assign done   = expire;

endmodule

// File: rtl/debug_access_ctrl.sv
// Debug-select initiator: takes debugger commands, gates access to the
// sensitive selector behind a key unlock with failure lockout, drives
// dbg_mode toward the target and returns one response per command.
module debug_access_ctrl #(
  parameter int DATA_W      = 32,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_sel,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] unlock_key,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [3:0]        dbg_mode,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              unlocked,
  output logic              lockout
);

  import dbg_pkg::*;

  localparam int WW = $clog2(RD_LAT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LAT - 1);

  dbg_state_e        state_q, state_d;
  dbg_op_e           op_q;
  logic [3:0]        sel_q;
  logic [DATA_W-1:0] key_q;
  logic [WW-1:0]     wait_q;

  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic [3:0]        dbg_mode_q;
  logic              unlocked_q;
  logic              lockout_q;

  logic              accept;
  logic              key_match;
  logic              read_grant;
  logic              rsp_hs;
  logic              unlock_fail;
  logic              unlock_ok;
  logic              lock_start;
  logic              at_max;
  logic              lock_done;

  assign accept      = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
  assign key_match   = (key_q == unlock_key);
  // Only the sensitive selector is gated; every other selector is always readable.
  assign read_grant  = (sel_q != SENS_SEL) || unlocked_q;
  assign rsp_hs      = (state_q == ST_RESP) && rsp_ready;
  assign unlock_ok   = (state_q == ST_CHECK) && (op_q == OP_UNLOCK) && key_match;
  assign unlock_fail = (state_q == ST_CHECK) && (op_q == OP_UNLOCK) && !key_match;
  assign lock_start  = rsp_hs && at_max;

  dbg_lockout_timer #(
    .MAX_FAILS   (MAX_FAILS),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .fail    (unlock_fail),
    .success (unlock_ok),
    .start   (lock_start),
    .at_max  (at_max),
    .done    (lock_done)
  );

  // Next-state decode for the controller FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_CHECK;
      ST_CHECK:   state_d = ((op_q == OP_READ) && read_grant) ? ST_ISSUE : ST_RESP;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (wait_q == '0) state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = at_max ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT: if (lock_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Command fields are captured on acceptance and held until the next one.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= dbg_op_e'(cmd_op);
      sel_q <= cmd_sel;
      key_q <= cmd_data;
    end
  end

  // FSM state plus registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      dbg_mode_q  <= DBG_IDLE;
      unlocked_q  <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      lockout_q   <= (state_d == ST_LOCKOUT);
      dbg_mode_q  <= ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) ? sel_q : DBG_IDLE;

      // Read latency counter: loaded in ISSUE, counts down across WAIT.
      if (state_q == ST_ISSUE) begin
        wait_q <= WAIT_LAST;
      end else if ((state_q == ST_WAIT) && (wait_q != '0)) begin
        wait_q <= wait_q - 1'b1;
      end

      // Resolve the command; non-read and denied-read responses carry zero data.
      if (state_q == ST_CHECK) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b0;
        case (op_q)
          OP_UNLOCK: begin
            if (key_match) unlocked_q <= 1'b1;
            rsp_err_q <= !key_match;
          end
          OP_LOCK:  unlocked_q <= 1'b0;
          OP_READ:  rsp_err_q  <= !read_grant;
          default:  ;
        endcase
      end

      // Target data is sampled on the edge that leaves the final WAIT cycle.
      if ((state_q == ST_WAIT) && (wait_q == '0)) begin
        rsp_data_q <= dbg_data;
        rsp_err_q  <= 1'b0;
      end

      // Lockout always revokes access, even if the session was unlocked.
      if (state_d == ST_LOCKOUT) begin
        unlocked_q <= 1'b0;
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_mode  = dbg_mode_q;
  assign unlocked  = unlocked_q;
  assign lockout   = lockout_q;

endmodule
